// File: rtl/ex_wram_arb.sv
// Work-RAM arbiter: CPU has absolute priority, background engine dumps/restores all 8 KB as byte streams.
// Defining EX_WRAM_CLEAR_EN makes reset release zero the whole RAM before the block goes idle.
module ex_wram_arb (
  input  logic        clk,
  input  logic        map_rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        ss_start,
  input  logic        ss_dir,
  output logic        ss_busy,
  output logic        ss_done,
  output logic [7:0]  ss_out_dat,
  output logic        ss_out_vld,
  input  logic        ss_out_rdy,
  input  logic [7:0]  ss_in_dat,
  input  logic        ss_in_vld,
  output logic        ss_in_rdy,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_din,
  output logic        ram_we,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [2:0] {IDLE, DUMP, RESTORE, DONE, CLEAR} state_t;

`ifdef EX_WRAM_CLEAR_EN
  localparam state_t RST_STATE = CLEAR;
`else
  localparam state_t RST_STATE = IDLE;
`endif

  state_t      state, state_nxt;
  logic [12:0] ptr;
  logic        rd_pend;
  logic        cpu_rd_pend;
  logic [7:0]  cpu_dout_q;
  logic        dump_issue, in_fire, clr_wr, last_ptr;

  assign last_ptr = (ptr == 13'h1FFF);

  always_comb begin
    state_nxt  = state;
    dump_issue = 1'b0;
    in_fire    = 1'b0;
    clr_wr     = 1'b0;
    ss_in_rdy  = 1'b0;
    case (state)
      IDLE:    if (ss_start) state_nxt = ss_dir ? RESTORE : DUMP;
      DUMP: begin
        dump_issue = !cpu_req && !ss_out_vld && !rd_pend;
        // pointer has wrapped to 0 only once byte 8191 sits in the output buffer
        if (ss_out_vld && ss_out_rdy && ptr == 13'd0) state_nxt = DONE;
      end
      RESTORE: begin
        ss_in_rdy = !cpu_req;
        in_fire   = ss_in_rdy && ss_in_vld;
        if (in_fire && last_ptr) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      CLEAR: begin
        clr_wr = !cpu_req;
        if (clr_wr && last_ptr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = ptr;
    ram_din  = 8'h00;
    ram_we   = 1'b0;
    if (cpu_req) begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_we;
    end else if (in_fire) begin
      ram_din = ss_in_dat;
      ram_we  = 1'b1;
    end else if (clr_wr) begin
      ram_we = 1'b1;
    end
    if (map_rst) ram_we = 1'b0;
  end

  assign ss_busy  = (state != IDLE) && !map_rst;
  assign ss_done  = (state == DONE);
  assign cpu_dout = cpu_rd_pend ? ram_dout : cpu_dout_q;

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      state       <= RST_STATE;
      ptr         <= 13'd0;
      rd_pend     <= 1'b0;
      ss_out_vld  <= 1'b0;
      ss_out_dat  <= 8'h00;
      cpu_ack     <= 1'b0;
      cpu_rd_pend <= 1'b0;
      cpu_dout_q  <= 8'h00;
    end else begin
      state       <= state_nxt;
      cpu_ack     <= cpu_req;
      cpu_rd_pend <= cpu_req && !cpu_we;
      if (cpu_rd_pend) cpu_dout_q <= ram_dout;
      // a dump read is only issued with cpu_req low, so ram_dout next cycle is ours
      rd_pend <= dump_issue;
      if (rd_pend) begin
        ss_out_dat <= ram_dout;
        ss_out_vld <= 1'b1;
        ptr        <= ptr + 13'd1;
      end else if (ss_out_vld && ss_out_rdy) begin
        ss_out_vld <= 1'b0;
      end
      if (in_fire || clr_wr) ptr <= ptr + 13'd1;
      if (state == IDLE && ss_start) ptr <= 13'd0;
    end
  end

endmodule
